// File: rtl/mod_147_3_3_rx_pkg.sv
// Shared constants for the 10BASE-T1S PCS receive stage: rx_cmd codes,
// 5B control symbols, FSM states and the idle-time symbol classifier.
package mod_147_3_3_rx_pkg;

  typedef enum logic [1:0] {
    CMD_BEACON    = 2'b00,
    CMD_COMMIT    = 2'b01,
    CMD_HEARTBEAT = 2'b10,
    CMD_NONE      = 2'b11
  } rx_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_DATA = 2'b10,
    ST_ESD  = 2'b11
  } rx_state_e;

  localparam logic [4:0] SYM_I = 5'b11111;
  localparam logic [4:0] SYM_J = 5'b11000;
  localparam logic [4:0] SYM_K = 5'b10001;
  localparam logic [4:0] SYM_T = 5'b01101;
  localparam logic [4:0] SYM_R = 5'b00111;
  localparam logic [4:0] SYM_H = 5'b00100;
  localparam logic [4:0] SYM_N = 5'b01000;
  localparam logic [4:0] SYM_B = 5'b11001;

  typedef struct packed {
    rx_state_e  st;
    rx_cmd_e    cmd;
    logic       crs;
    logic [2:0] cnt;
  } idle_res_t;

  // What a symbol means when seen outside a frame; also used when SYNC bails out.
  function automatic idle_res_t idle_classify(input logic [4:0] sym);
    idle_res_t r;
    r = '{st: ST_IDLE, cmd: CMD_NONE, crs: 1'b0, cnt: 3'd0};
    case (sym)
      SYM_N: r.cmd = CMD_BEACON;
      SYM_B: r.cmd = CMD_HEARTBEAT;
      SYM_J: r = '{st: ST_SYNC, cmd: CMD_COMMIT, crs: 1'b1, cnt: 3'd1};
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mod_147_3_3_dec5b4b.sv
// Combinational 4B/5B data decoder; is_data=0 for any non-data code group.
module mod_147_3_3_dec5b4b (
  input  logic [4:0] sym,
  output logic [3:0] nibble,
  output logic       is_data
);

  always_comb begin
    nibble  = 4'h0;
    is_data = 1'b1;
    case (sym)
      5'b11110: nibble = 4'h0;
      5'b01001: nibble = 4'h1;
      5'b10100: nibble = 4'h2;
      5'b10101: nibble = 4'h3;
      5'b01010: nibble = 4'h4;
      5'b01011: nibble = 4'h5;
      5'b01110: nibble = 4'h6;
      5'b01111: nibble = 4'h7;
      5'b10010: nibble = 4'h8;
      5'b10011: nibble = 4'h9;
      5'b10110: nibble = 4'hA;
      5'b10111: nibble = 4'hB;
      5'b11010: nibble = 4'hC;
      5'b11011: nibble = 4'hD;
      5'b11100: nibble = 4'hE;
      5'b11101: nibble = 4'hF;
      default:  is_data = 1'b0;
    endcase
  end

endmodule

// File: rtl/mod_147_3_3_rx.sv
// 10BASE-T1S PCS receive: idle command detect, SSD sync, 5B/4B decode,
// ESD/ESDERR termination. All outputs registered, advancing only on strobes.
module mod_147_3_3_rx
  import mod_147_3_3_rx_pkg::*;
#(
  parameter int SYNC_MIN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pcs_reset,
  input  logic [4:0] rx_sym,
  input  logic       rx_sym_valid,
  output logic [1:0] rx_cmd,
  output logic       RX_DV,
  output logic [3:0] RXD,
  output logic       RX_ER,
  output logic       CRS
);

  localparam logic [2:0] SYNC_MIN_C = 3'(SYNC_MIN);

  rx_state_e  state;
  logic [2:0] sync_cnt;
  logic       last_i;   // previous DATA strobe was I
  logic       esd_err;  // ESDERR seen, frame closes on next strobe

  logic [3:0] nibble;
  logic       is_data;
  idle_res_t  idle_r;

  mod_147_3_3_dec5b4b u_dec (
    .sym     (rx_sym),
    .nibble  (nibble),
    .is_data (is_data)
  );

  assign idle_r = idle_classify(rx_sym);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rx_cmd   <= CMD_NONE;
      RX_DV    <= 1'b0;
      RXD      <= 4'h0;
      RX_ER    <= 1'b0;
      CRS      <= 1'b0;
      sync_cnt <= 3'd0;
      last_i   <= 1'b0;
      esd_err  <= 1'b0;
    end else if (pcs_reset) begin
      state    <= ST_IDLE;
      rx_cmd   <= CMD_NONE;
      RX_DV    <= 1'b0;
      RXD      <= 4'h0;
      RX_ER    <= 1'b0;
      CRS      <= 1'b0;
      sync_cnt <= 3'd0;
      last_i   <= 1'b0;
      esd_err  <= 1'b0;
    end else if (rx_sym_valid) begin
      case (state)
        ST_IDLE: begin
          state    <= idle_r.st;
          rx_cmd   <= idle_r.cmd;
          CRS      <= idle_r.crs;
          sync_cnt <= idle_r.cnt;
          RX_DV    <= 1'b0;
          RX_ER    <= 1'b0;
        end
        ST_SYNC: begin
          if (rx_sym == SYM_J) begin
            rx_cmd <= CMD_COMMIT;
            if (sync_cnt != 3'd7) sync_cnt <= sync_cnt + 3'd1;
          end else if (rx_sym == SYM_K && sync_cnt >= SYNC_MIN_C) begin
            state  <= ST_DATA;
            rx_cmd <= CMD_NONE;
            last_i <= 1'b0;
          end else begin
            // Failed sync: the symbol is reinterpreted as an idle-time symbol.
            state    <= idle_r.st;
            rx_cmd   <= idle_r.cmd;
            CRS      <= idle_r.crs;
            sync_cnt <= idle_r.cnt;
          end
        end
        ST_DATA: begin
          rx_cmd <= CMD_NONE;
          if (rx_sym == SYM_I && last_i) begin
            state    <= ST_IDLE;
            RX_DV    <= 1'b0;
            RX_ER    <= 1'b0;
            CRS      <= 1'b0;
            sync_cnt <= 3'd0;
            last_i   <= 1'b0;
          end else if (is_data) begin
            RXD    <= nibble;
            RX_DV  <= 1'b1;
            RX_ER  <= 1'b0;
            last_i <= 1'b0;
          end else if (rx_sym == SYM_T) begin
            state   <= ST_ESD;
            RX_ER   <= 1'b0;
            last_i  <= 1'b0;
            esd_err <= 1'b0;
          end else begin
            RX_DV  <= 1'b1;
            RX_ER  <= 1'b1;
            last_i <= (rx_sym == SYM_I);
          end
        end
        ST_ESD: begin
          rx_cmd <= CMD_NONE;
          if (esd_err || rx_sym == SYM_R) begin
            state    <= ST_IDLE;
            RX_DV    <= 1'b0;
            RX_ER    <= 1'b0;
            CRS      <= 1'b0;
            sync_cnt <= 3'd0;
            esd_err  <= 1'b0;
          end else begin
            RX_DV   <= 1'b1;
            RX_ER   <= 1'b1;
            esd_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_147_3_3_rx.sv
// Directed bench for mod_147_3_3_rx: table of strobes with hand-computed outputs,
// plus sequences for async/sync reset and strobe-gating.
module tb_mod_147_3_3_rx;

  localparam logic [4:0] I = 5'b11111, J = 5'b11000, K = 5'b10001, T = 5'b01101;
  localparam logic [4:0] R = 5'b00111, H = 5'b00100, N = 5'b01000, B = 5'b11001;
  localparam logic [4:0] D1 = 5'b01001, D3 = 5'b10101, D4 = 5'b01010, D5 = 5'b01011;
  localparam logic [4:0] D7 = 5'b01111, DA = 5'b10110, D2 = 5'b10100;
  localparam logic [1:0] BCN = 2'b00, CMT = 2'b01, HBT = 2'b10, NON = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pcs_reset = 1'b0;
  logic [4:0] rx_sym = 5'b0;
  logic       rx_sym_valid = 1'b0;
  logic [1:0] rx_cmd;
  logic       RX_DV, RX_ER, CRS;
  logic [3:0] RXD;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] sym;
    logic [1:0] cmd;
    logic       dv;
    logic [3:0] rxd;
    logic       er;
    logic       crs;
  } vec_t;

  vec_t tbl[$];

  mod_147_3_3_rx #(.SYNC_MIN(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pcs_reset    (pcs_reset),
    .rx_sym       (rx_sym),
    .rx_sym_valid (rx_sym_valid),
    .rx_cmd       (rx_cmd),
    .RX_DV        (RX_DV),
    .RXD          (RXD),
    .RX_ER        (RX_ER),
    .CRS          (CRS)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] cmd, input logic dv,
                       input logic [3:0] rxd, input logic er, input logic crs);
    n_cmp++;
    if (rx_cmd !== cmd || RX_DV !== dv || RXD !== rxd || RX_ER !== er || CRS !== crs) begin
      n_bad++;
      $display("FAIL %s: got cmd=%b dv=%b rxd=%h er=%b crs=%b, want cmd=%b dv=%b rxd=%h er=%b crs=%b",
               name, rx_cmd, RX_DV, RXD, RX_ER, CRS, cmd, dv, rxd, er, crs);
    end
  endtask

  // One-clock strobe driven at negedge; outputs sampled at the following negedge.
  task automatic strobe(input logic [4:0] sym);
    @(negedge clk);
    rx_sym       = sym;
    rx_sym_valid = 1'b1;
    @(negedge clk);
    rx_sym_valid = 1'b0;
  endtask

  initial begin
    // idle commands
    tbl.push_back('{I, NON, 0, 4'h0, 0, 0});
    tbl.push_back('{N, BCN, 0, 4'h0, 0, 0});
    tbl.push_back('{I, NON, 0, 4'h0, 0, 0});
    tbl.push_back('{B, HBT, 0, 4'h0, 0, 0});
    tbl.push_back('{I, NON, 0, 4'h0, 0, 0});
    // clean frame 5, A
    tbl.push_back('{J,  CMT, 0, 4'h0, 0, 1});
    tbl.push_back('{J,  CMT, 0, 4'h0, 0, 1});
    tbl.push_back('{K,  NON, 0, 4'h0, 0, 1});
    tbl.push_back('{D5, NON, 1, 4'h5, 0, 1});
    tbl.push_back('{DA, NON, 1, 4'hA, 0, 1});
    tbl.push_back('{T,  NON, 1, 4'hA, 0, 1});
    tbl.push_back('{R,  NON, 0, 4'hA, 0, 0});
    // short sync: K after one J falls back to idle
    tbl.push_back('{J, CMT, 0, 4'hA, 0, 1});
    tbl.push_back('{K, NON, 0, 4'hA, 0, 0});
    // non-K in SYNC is reclassified as idle symbol
    tbl.push_back('{J, CMT, 0, 4'hA, 0, 1});
    tbl.push_back('{N, BCN, 0, 4'hA, 0, 0});
    // errored frame with ESDERR
    tbl.push_back('{J,  CMT, 0, 4'hA, 0, 1});
    tbl.push_back('{J,  CMT, 0, 4'hA, 0, 1});
    tbl.push_back('{K,  NON, 0, 4'hA, 0, 1});
    tbl.push_back('{D3, NON, 1, 4'h3, 0, 1});
    tbl.push_back('{H,  NON, 1, 4'h3, 1, 1});
    tbl.push_back('{D4, NON, 1, 4'h4, 0, 1});
    tbl.push_back('{T,  NON, 1, 4'h4, 0, 1});
    tbl.push_back('{H,  NON, 1, 4'h4, 1, 1});
    tbl.push_back('{I,  NON, 0, 4'h4, 0, 0});
    tbl.push_back('{B,  HBT, 0, 4'h4, 0, 0});
    // abort on I,I; three J before K also syncs
    tbl.push_back('{J,  CMT, 0, 4'h4, 0, 1});
    tbl.push_back('{J,  CMT, 0, 4'h4, 0, 1});
    tbl.push_back('{J,  CMT, 0, 4'h4, 0, 1});
    tbl.push_back('{K,  NON, 0, 4'h4, 0, 1});
    tbl.push_back('{D1, NON, 1, 4'h1, 0, 1});
    tbl.push_back('{I,  NON, 1, 4'h1, 1, 1});
    tbl.push_back('{I,  NON, 0, 4'h1, 0, 0});
    tbl.push_back('{N,  BCN, 0, 4'h1, 0, 0});

    repeat (2) @(negedge clk);
    check("reset_state", NON, 0, 4'h0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      strobe(tbl[i].sym);
      check($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].dv, tbl[i].rxd, tbl[i].er, tbl[i].crs);
    end

    // async reset mid-DATA, then restart
    strobe(J); strobe(J); strobe(K); strobe(D7);
    check("pre_async_rst", NON, 1, 4'h7, 0, 1);
    #2 reset_n = 1'b0;
    #1 check("async_rst", NON, 0, 4'h0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    strobe(J);
    check("restart_j", CMT, 0, 4'h0, 0, 1);
    strobe(J); strobe(K); strobe(D2);
    check("restart_data", NON, 1, 4'h2, 0, 1);

    // sync reset takes effect only at the clock edge
    @(negedge clk);
    pcs_reset = 1'b1;
    #1 check("pcs_rst_pre_edge", NON, 1, 4'h2, 0, 1);
    @(negedge clk);
    pcs_reset = 1'b0;
    check("pcs_rst", NON, 0, 4'h0, 0, 0);

    // no strobe: nothing moves
    strobe(J);
    rx_sym = K;
    repeat (3) @(negedge clk);
    check("hold_no_strobe", CMT, 0, 4'h0, 0, 1);
    strobe(K);
    check("short_sync2", NON, 0, 4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
